// File: rtl/vga_timing_gen.sv
// Raster timing for 640x480@60: pixel/line counters, registered blank and strobes,
// plus hs/vs passed through a PIPE_DELAY-deep line so they stay aligned with registered RGB.
module vga_timing_gen #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter int   PIPE_DELAY  = 2,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       frame_start,
  output logic       line_start,
  output logic       hs,
  output logic       vs
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be within 0..7");
  end
  if (H_TOTAL >= 1024 || V_TOTAL >= 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit in 10 bits");
  end

  logic                  run;
  logic [9:0]            x_nxt;
  logic [9:0]            y_nxt;
  logic                  hs_nxt;
  logic                  vs_nxt;
  // Bit 0 is the registered raw sync (aligned with DrawX); the top bit drives the pin.
  logic [PIPE_DELAY:0]   hs_sr;
  logic [PIPE_DELAY:0]   vs_sr;

  // Until the run flag is set the next pixel is (0,0), so the first edge after reset presents it.
  always_comb begin
    x_nxt = '0;
    y_nxt = '0;
    if (run) begin
      if (DrawX == H_LAST) begin
        x_nxt = '0;
        y_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
      end else begin
        x_nxt = DrawX + 10'd1;
        y_nxt = DrawY;
      end
    end
    hs_nxt = (x_nxt >= HS_FIRST && x_nxt <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_nxt = (y_nxt >= VS_FIRST && y_nxt <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      run         <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      hs_sr       <= {(PIPE_DELAY + 1){~SYNC_ACTIVE}};
      vs_sr       <= {(PIPE_DELAY + 1){~SYNC_ACTIVE}};
    end else begin
      run         <= 1'b1;
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      blank       <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
      line_start  <= (x_nxt == 10'd0);
      hs_sr       <= (PIPE_DELAY + 1)'({hs_sr, hs_nxt});
      vs_sr       <= (PIPE_DELAY + 1)'({vs_sr, vs_nxt});
    end
  end

  assign hs = hs_sr[PIPE_DELAY];
  assign vs = vs_sr[PIPE_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: a default instance, a zero-delay/active-high instance, and a tiny
// raster instance for frame-level and mid-frame-reset behaviour.
module tb_vga_timing_gen;

  typedef struct {
    int tag;
    int val;
  } exp_t;

  localparam int T_RST = 0, T_FS = 1, T_LSP = 2, T_BF = 3, T_HF = 4, T_HR = 5,
                 T_HON = 6, T_HOFF = 7, T_PQ = 8, T_VF = 9, T_VR = 10, T_WRAP = 11,
                 T_FSP = 12, T_BCNT = 13, T_VRST = 14, T_RANGE = 15;

  bit   clk;
  logic rst_a;
  logic rst_s;
  int   cyc;
  int   total;
  int   bad;
  bit   a_en = 1'b1;
  bit   s_en = 1'b1;

  exp_t qa[$];
  exp_t qv[$];
  exp_t qs[$];

  logic [9:0] a_x, a_y, v_x, v_y, s_x, s_y;
  logic a_blank, a_fs, a_ls, a_hs, a_vs;
  logic v_blank, v_fs, v_ls, v_hs, v_vs;
  logic s_blank, s_fs, s_ls, s_hs, s_vs;

  vga_timing_gen u_dut (
    .vga_clk(clk), .reset(rst_a), .DrawX(a_x), .DrawY(a_y), .blank(a_blank),
    .frame_start(a_fs), .line_start(a_ls), .hs(a_hs), .vs(a_vs)
  );

  vga_timing_gen #(.PIPE_DELAY(0), .SYNC_ACTIVE(1'b1)) u_var (
    .vga_clk(clk), .reset(rst_a), .DrawX(v_x), .DrawY(v_y), .blank(v_blank),
    .frame_start(v_fs), .line_start(v_ls), .hs(v_hs), .vs(v_vs)
  );

  // 15 x 13 raster: sync rows 8..9, 48 visible pixels, 195 cycles per frame.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_small (
    .vga_clk(clk), .reset(rst_s), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .frame_start(s_fs), .line_start(s_ls), .hs(s_hs), .vs(s_vs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string tag_name(input int t);
    case (t)
      T_RST:   return "reset_state";
      T_FS:    return "frame_start_pixel";
      T_LSP:   return "line_start_period";
      T_BF:    return "blank_fall_x";
      T_HF:    return "hs_assert_delay";
      T_HR:    return "hs_width";
      T_HON:   return "hs_on_x";
      T_HOFF:  return "hs_off_x";
      T_PQ:    return "sync_quiet_after_release";
      T_VF:    return "vs_assert_delay";
      T_VR:    return "vs_width";
      T_WRAP:  return "frame_wrap";
      T_FSP:   return "frame_period";
      T_BCNT:  return "visible_count";
      T_VRST:  return "vs_async_reset";
      T_RANGE: return "counter_range";
      default: return "unknown";
    endcase
  endfunction

  function automatic string q_name(input int q);
    case (q)
      0:       return "dut";
      1:       return "var";
      default: return "small";
    endcase
  endfunction

  task automatic push(input int q, input int tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    case (q)
      0:       qa.push_back(e);
      1:       qv.push_back(e);
      default: qs.push_back(e);
    endcase
  endtask

  task automatic sb(input int q, input int tag, input int val);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (q)
      0:       if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      1:       if (qv.size() > 0) begin e = qv.pop_front(); have = 1'b1; end
      default: if (qs.size() > 0) begin e = qs.pop_front(); have = 1'b1; end
    endcase
    total++;
    if (!have) begin
      bad++;
      $display("FAIL %s/%s: unexpected event, got %0d, required none", q_name(q), tag_name(tag), val);
    end else if (e.tag != tag || e.val != val) begin
      bad++;
      $display("FAIL %s/%s: got %s=%0d, required %s=%0d", q_name(q), tag_name(e.tag),
               tag_name(tag), val, tag_name(e.tag), e.val);
    end
  endtask

  // Default instance monitor
  int a_ls_cyc, a_hs_cyc;
  bit a_have_ls;
  logic a_prev_blank = 1'b0;
  logic a_prev_hs = 1'b1;

  always @(negedge clk) begin
    if (a_en) begin
      if (rst_a) begin
        sb(0, T_RST, int'({a_x, a_y, a_blank, a_hs, a_vs, a_fs, a_ls}));
        a_have_ls = 1'b0;
      end else begin
        if (a_fs) sb(0, T_FS, int'({a_x, a_y, a_blank, a_ls}));
        if (a_ls) begin
          if (a_have_ls) sb(0, T_LSP, cyc - a_ls_cyc);
          a_ls_cyc  = cyc;
          a_have_ls = 1'b1;
        end
        if (a_prev_blank && !a_blank) sb(0, T_BF, int'(a_x));
        if (a_prev_hs && !a_hs) begin
          sb(0, T_HF, cyc - a_ls_cyc);
          a_hs_cyc = cyc;
        end
        if (!a_prev_hs && a_hs) sb(0, T_HR, cyc - a_hs_cyc);
      end
      a_prev_blank = a_blank;
      a_prev_hs    = a_hs;
    end
  end

  // Zero-delay, active-high instance monitor
  logic v_prev_hs = 1'b0;

  always @(negedge clk) begin
    if (a_en) begin
      if (!rst_a) begin
        if (!v_prev_hs && v_hs) sb(1, T_HON, int'(v_x));
        if (v_prev_hs && !v_hs) sb(1, T_HOFF, int'(v_x));
      end
      v_prev_hs = v_hs;
    end
  end

  // Small raster monitor
  int s_fs_cyc, s_mark, s_vf_cyc, s_bcnt, s_rel, s_glitch;
  bit s_have_fs, s_corner;
  logic s_prev_rst = 1'b1;
  logic s_prev_vs = 1'b1;

  always @(negedge clk) begin
    if (s_en) begin
      if (rst_s) begin
        if (!s_prev_rst) sb(2, T_VRST, int'({s_vs, s_hs, s_x, s_y}));
        s_have_fs = 1'b0;
        s_bcnt    = 0;
        s_rel     = 0;
        s_glitch  = 0;
        s_corner  = 1'b0;
      end else begin
        if (s_rel < 6) begin
          if (!s_hs || !s_vs) s_glitch++;
          s_rel++;
          if (s_rel == 6) sb(2, T_PQ, s_glitch);
        end
        if (s_corner) sb(2, T_WRAP, int'({s_x, s_y, s_fs}));
        if (s_x >= 10'd15 || s_y >= 10'd13) sb(2, T_RANGE, int'({s_x, s_y}));
        if (s_fs) begin
          if (s_have_fs) begin
            sb(2, T_FSP, cyc - s_fs_cyc);
            sb(2, T_BCNT, s_bcnt);
          end
          s_fs_cyc  = cyc;
          s_have_fs = 1'b1;
          s_bcnt    = 0;
        end
        if (s_blank) s_bcnt++;
        if (s_x == 10'd0 && s_y == 10'd8) s_mark = cyc;
        if (s_prev_vs && !s_vs) begin
          sb(2, T_VF, cyc - s_mark);
          s_vf_cyc = cyc;
        end
        if (!s_prev_vs && s_vs) sb(2, T_VR, cyc - s_vf_cyc);
        s_corner = (s_x == 10'd14 && s_y == 10'd12);
      end
      s_prev_rst = rst_s;
      s_prev_vs  = s_vs;
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_s = 1'b1;

    // Default instance: 5 reset samples, release pixel, then three lines.
    for (int i = 0; i < 5; i++)
      push(0, T_RST, int'({10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
    push(0, T_FS, int'({10'd0, 10'd0, 1'b1, 1'b1}));
    for (int l = 0; l < 3; l++) begin
      if (l > 0) push(0, T_LSP, 800);
      push(0, T_BF, 640);
      push(0, T_HF, 658);
      push(0, T_HR, 96);
    end

    for (int l = 0; l < 3; l++) begin
      push(1, T_HON, 656);
      push(1, T_HOFF, 752);
    end

    push(2, T_PQ, 0);
    for (int f = 0; f < 2; f++) begin
      push(2, T_VF, 2);
      push(2, T_VR, 30);
      push(2, T_WRAP, 1);
      push(2, T_FSP, 195);
      push(2, T_BCNT, 48);
    end
    push(2, T_VF, 2);
    push(2, T_VRST, int'({1'b1, 1'b1, 10'd0, 10'd0}));
    push(2, T_PQ, 0);

    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    rst_s = 1'b0;

    fork
      begin
        repeat (2380) @(negedge clk);
        a_en = 1'b0;
      end
      begin
        int n;
        n = 0;
        repeat (400) @(negedge clk);
        while (!(s_y == 10'd8 && s_x == 10'd6) && n < 2000) begin
          @(negedge clk);
          n++;
        end
        if (n >= 2000) begin
          total++;
          bad++;
          $display("FAIL small/midframe_wait: got no DrawY=8 within %0d cycles, required one", n);
        end
        @(posedge clk);
        #2;
        rst_s = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_s = 1'b0;
        repeat (20) @(negedge clk);
        s_en = 1'b0;
      end
    join

    while (qa.size() > 0) begin
      exp_t e;
      e = qa.pop_front();
      total++; bad++;
      $display("FAIL dut/%s: got no event, required %0d", tag_name(e.tag), e.val);
    end
    while (qv.size() > 0) begin
      exp_t e;
      e = qv.pop_front();
      total++; bad++;
      $display("FAIL var/%s: got no event, required %0d", tag_name(e.tag), e.val);
    end
    while (qs.size() > 0) begin
      exp_t e;
      e = qs.pop_front();
      total++; bad++;
      $display("FAIL small/%s: got no event, required %0d", tag_name(e.tag), e.val);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
